// File: rtl/axis_frame_fifo_sf_if.sv
// AXI4-Stream bundle used on both sides of axis_frame_fifo_sf.
//
// Signals:
//   tdata  - payload word
//   tkeep  - byte enables
//   tvalid - beat valid
//   tready - beat ready (driven by the sink)
//   tlast  - last beat of a frame
//   tuser  - sideband; bit 0 flags a bad frame on the tlast beat
//
// Modports:
//   master - stream source (drives everything except tready)
//   slave  - stream sink (drives tready only)
interface axis_frame_fifo_sf_if #(
    parameter int DATA_WIDTH = 8,
    parameter int KEEP_WIDTH = 1,
    parameter int USER_WIDTH = 1
);
    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;

    modport master (
        output tdata, tkeep, tvalid, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast, tuser,
        output tready
    );
endinterface

// File: rtl/axis_frame_fifo_sf.sv
// Store-and-forward AXI4-Stream frame FIFO.
//
// Only complete, committed frames become visible on the read side, so a
// downstream arbiter never stalls mid-packet. Frames that overflow the buffer
// or end with the bad-frame flag (tuser[0] on tlast) are discarded in full.
// The write side never back-pressures: s_axis.tready is held high outside
// reset.
//
// Ports:
//   clk               - clock
//   rst               - asynchronous active-high reset
//   s_axis            - input stream (slave modport)
//   m_axis            - output stream (master modport)
//   status_overflow   - 1-cycle pulse: frame dropped for lack of space
//   status_bad_frame  - 1-cycle pulse: frame dropped for bad-frame flag
//   status_good_frame - 1-cycle pulse: frame committed
module axis_frame_fifo_sf #(
    parameter int DEPTH          = 1024,
    parameter int DATA_WIDTH     = 8,
    parameter int KEEP_ENABLE    = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH     = (DATA_WIDTH / 8),
    parameter int USER_ENABLE    = 1,
    parameter int USER_WIDTH     = 1,
    parameter int DROP_BAD_FRAME = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    axis_frame_fifo_sf_if.slave   s_axis,
    axis_frame_fifo_sf_if.master  m_axis,
    output logic                  status_overflow,
    output logic                  status_bad_frame,
    output logic                  status_good_frame
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int PTR_WIDTH  = ADDR_WIDTH + 1;
    localparam int WORD_WIDTH = DATA_WIDTH + KEEP_WIDTH + USER_WIDTH + 1;

    localparam int KEEP_LSB = DATA_WIDTH;
    localparam int USER_LSB = DATA_WIDTH + KEEP_WIDTH;
    localparam int LAST_BIT = WORD_WIDTH - 1;

    localparam logic [PTR_WIDTH-1:0] PTR_INC = PTR_WIDTH'(1);

    // Storage
    logic [WORD_WIDTH-1:0] mem [DEPTH];

    // Write side state
    logic [PTR_WIDTH-1:0] wr_ptr_cur;
    logic [PTR_WIDTH-1:0] wr_ptr_commit;
    logic                 drop_frame;
    logic                 s_ready_q;
    logic                 overflow_q;
    logic                 bad_frame_q;
    logic                 good_frame_q;

    // Read side state
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic [PTR_WIDTH-1:0]  wr_ptr_commit_rd;
    logic                  rd_valid;
    logic [WORD_WIDTH-1:0] rd_word;
    logic                  out_valid;
    logic [WORD_WIDTH-1:0] out_word;

    // Combinational helpers
    logic                  full;
    logic                  empty;
    logic                  s_beat;
    logic                  wr_en;
    logic                  wr_bad;
    logic [KEEP_WIDTH-1:0] wr_keep;
    logic [USER_WIDTH-1:0] wr_user;
    logic [WORD_WIDTH-1:0] wr_word;
    logic                  out_ready;
    logic                  stage_ready;
    logic                  rd_en;

    // ------------------------------------------------------------------
    // Status and flags
    // ------------------------------------------------------------------
    always_comb begin
        // Full: pointers differ by exactly DEPTH (MSB differs, address equal).
        full  = (wr_ptr_cur[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                (wr_ptr_cur[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
        // Empty is judged against the read side's copy of the commit pointer.
        empty = (wr_ptr_commit_rd == rd_ptr);
    end

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    always_comb begin
        wr_keep = (KEEP_ENABLE != 0) ? s_axis.tkeep : '1;
        wr_user = (USER_ENABLE != 0) ? s_axis.tuser : '0;
        wr_word = {s_axis.tlast, wr_user, wr_keep, s_axis.tdata};
        s_beat  = s_ready_q && s_axis.tvalid;
        wr_en   = s_beat && !full && !drop_frame;
        wr_bad  = (DROP_BAD_FRAME != 0) && s_axis.tuser[0];
    end

    assign s_axis.tready     = s_ready_q;
    assign status_overflow   = overflow_q;
    assign status_bad_frame  = bad_frame_q;
    assign status_good_frame = good_frame_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_cur[ADDR_WIDTH-1:0]] <= wr_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_cur    <= '0;
            wr_ptr_commit <= '0;
            drop_frame    <= 1'b0;
            s_ready_q     <= 1'b0;
            overflow_q    <= 1'b0;
            bad_frame_q   <= 1'b0;
            good_frame_q  <= 1'b0;
        end else begin
            s_ready_q    <= 1'b1;
            overflow_q   <= 1'b0;
            bad_frame_q  <= 1'b0;
            good_frame_q <= 1'b0;

            if (s_beat) begin
                if (full || drop_frame) begin
                    // Discard the rest of this frame; roll back what was
                    // already written of it.
                    wr_ptr_cur <= wr_ptr_commit;
                    if (s_axis.tlast) begin
                        drop_frame <= 1'b0;
                        overflow_q <= 1'b1;
                    end else begin
                        drop_frame <= 1'b1;
                    end
                end else if (s_axis.tlast) begin
                    if (wr_bad) begin
                        wr_ptr_cur  <= wr_ptr_commit;
                        bad_frame_q <= 1'b1;
                    end else begin
                        wr_ptr_cur    <= wr_ptr_cur + PTR_INC;
                        wr_ptr_commit <= wr_ptr_cur + PTR_INC;
                        good_frame_q  <= 1'b1;
                    end
                end else begin
                    wr_ptr_cur <= wr_ptr_cur + PTR_INC;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read side: RAM read register followed by an output register.
    // Stage 1 may only refill when its word moves on (or it is empty), so
    // no read is issued that the pipeline cannot hold during a stall.
    // ------------------------------------------------------------------
    always_comb begin
        out_ready   = !out_valid || m_axis.tready;
        stage_ready = !rd_valid || out_ready;
        rd_en       = !empty && stage_ready;
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_word <= mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr           <= '0;
            wr_ptr_commit_rd <= '0;
            rd_valid         <= 1'b0;
            out_valid        <= 1'b0;
            out_word         <= '0;
        end else begin
            // Commits reach the read side one cycle after they are made.
            wr_ptr_commit_rd <= wr_ptr_commit;

            if (stage_ready) begin
                rd_valid <= rd_en;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_INC;
            end
            if (out_ready) begin
                out_valid <= rd_valid;
                if (rd_valid) begin
                    out_word <= rd_word;
                end
            end
        end
    end

    assign m_axis.tvalid = out_valid;
    assign m_axis.tdata  = out_word[DATA_WIDTH-1:0];
    assign m_axis.tkeep  = out_word[KEEP_LSB +: KEEP_WIDTH];
    assign m_axis.tuser  = out_word[USER_LSB +: USER_WIDTH];
    assign m_axis.tlast  = out_word[LAST_BIT];

endmodule

// File: tb/tb_axis_frame_fifo_sf.sv
// Self-checking bench for axis_frame_fifo_sf (DEPTH=16, DATA_WIDTH=8).
module tb_axis_frame_fifo_sf;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axis_frame_fifo_sf_if #(.DATA_WIDTH(8), .KEEP_WIDTH(1), .USER_WIDTH(1)) s_if ();
    axis_frame_fifo_sf_if #(.DATA_WIDTH(8), .KEEP_WIDTH(1), .USER_WIDTH(1)) m_if ();

    logic status_overflow;
    logic status_bad_frame;
    logic status_good_frame;

    axis_frame_fifo_sf #(
        .DEPTH(DEPTH),
        .DATA_WIDTH(8),
        .KEEP_ENABLE(0),
        .KEEP_WIDTH(1),
        .USER_ENABLE(1),
        .USER_WIDTH(1),
        .DROP_BAD_FRAME(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_axis(s_if),
        .m_axis(m_if),
        .status_overflow(status_overflow),
        .status_bad_frame(status_bad_frame),
        .status_good_frame(status_good_frame)
    );

    typedef struct {
        int         len;
        logic [7:0] first;
        logic       bad;
        int         exp_beats;
        int         exp_good;
        int         exp_bad;
        int         exp_ovf;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int tcount = 0;
    int n_good, n_bad, n_ovf, ovf_tick, last_tick, first_valid_tick, tready_low, keep_bad;
    logic [7:0] got_d[$];
    logic       got_l[$];
    logic       got_u[$];
    logic [7:0] exp_d[$];
    logic       exp_l[$];
    logic       exp_u[$];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic clear_obs();
        n_good = 0; n_bad = 0; n_ovf = 0;
        ovf_tick = -1; last_tick = -1; first_valid_tick = -1;
        tready_low = 0; keep_bad = 0;
        got_d.delete(); got_l.delete(); got_u.delete();
    endtask

    // One clock: drive inputs after the falling edge, then observe. Outputs
    // are registered, so what is seen here holds until the next rising edge,
    // where the handshake takes place.
    task automatic tick(input logic v, input logic [7:0] d, input logic l,
                        input logic u, input logic r);
        @(negedge clk);
        s_if.tvalid = v;
        s_if.tdata  = d;
        s_if.tlast  = l;
        s_if.tuser  = u;
        m_if.tready = r;
        #1;
        tcount++;
        if (status_good_frame) n_good++;
        if (status_bad_frame)  n_bad++;
        if (status_overflow) begin
            n_ovf++;
            ovf_tick = tcount;
        end
        if (first_valid_tick < 0 && m_if.tvalid) first_valid_tick = tcount;
        if (v && !s_if.tready) tready_low++;
        if (v && l) last_tick = tcount;
        if (m_if.tvalid && m_if.tready) begin
            got_d.push_back(m_if.tdata);
            got_l.push_back(m_if.tlast);
            got_u.push_back(m_if.tuser[0]);
            if (m_if.tkeep != 1'b1) keep_bad++;
        end
    endtask

    task automatic idle(input int n, input logic r);
        repeat (n) tick(1'b0, 8'h00, 1'b0, 1'b0, r);
    endtask

    task automatic send_frame(input int len, input logic [7:0] first,
                              input logic bad, input logic r);
        for (int i = 0; i < len; i++) begin
            tick(1'b1, first + 8'(i), (i == len - 1), bad && (i == len - 1), r);
        end
    endtask

    // Count output beats that deviate from an incrementing byte sequence
    // split into frames of 'period' beats with tuser clear.
    function automatic int seq_errors(input logic [7:0] first, input int period);
        int e = 0;
        for (int i = 0; i < got_d.size(); i++) begin
            if (got_d[i] != first + 8'(i)) e++;
            if (got_l[i] != ((i % period) == period - 1)) e++;
            if (got_u[i] != 1'b0) e++;
        end
        return e;
    endfunction

    initial begin
        vec_t tbl[8];
        int   waited;
        int   timeouts;
        int   mism;
        int   exp_good_cnt;
        int   exp_bad_cnt;

        tbl[0] = '{5,  8'h01, 1'b0, 5,  1, 0, 0};
        tbl[1] = '{5,  8'h01, 1'b1, 0,  0, 1, 0};
        tbl[2] = '{3,  8'h10, 1'b0, 3,  1, 0, 0};
        tbl[3] = '{20, 8'h20, 1'b0, 0,  0, 0, 1};
        tbl[4] = '{16, 8'h40, 1'b0, 16, 1, 0, 0};
        tbl[5] = '{17, 8'h60, 1'b0, 0,  0, 0, 1};
        tbl[6] = '{1,  8'h80, 1'b0, 1,  1, 0, 0};
        tbl[7] = '{1,  8'h90, 1'b1, 0,  0, 1, 0};

        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = 1'b1;
        s_if.tlast = 1'b0;  s_if.tuser = '0; m_if.tready = 1'b0;
        clear_obs();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_m_tvalid", m_if.tvalid, 0);
        check("rst_s_tready", s_if.tready, 0);
        check("rst_status", {status_overflow, status_bad_frame, status_good_frame}, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("tready_after_rst", s_if.tready, 1);

        // Table of single-frame cases, drained with m_axis_tready=1
        for (int k = 0; k < 8; k++) begin
            clear_obs();
            send_frame(tbl[k].len, tbl[k].first, tbl[k].bad, 1'b1);
            idle(30, 1'b1);
            check($sformatf("beats[%0d]", k), got_d.size(), tbl[k].exp_beats);
            check($sformatf("seq[%0d]", k), seq_errors(tbl[k].first, tbl[k].len), 0);
            check($sformatf("good[%0d]", k), n_good, tbl[k].exp_good);
            check($sformatf("bad[%0d]", k), n_bad, tbl[k].exp_bad);
            check($sformatf("ovf[%0d]", k), n_ovf, tbl[k].exp_ovf);
            check($sformatf("s_tready[%0d]", k), tready_low, 0);
            if (k == 0) check("latency", first_valid_tick - last_tick, 4);
        end

        // Overflow with output stalled: 3 x 5 beats fit, a 4-beat frame does not
        clear_obs();
        send_frame(5, 8'hA0, 1'b0, 1'b0);
        send_frame(5, 8'hA5, 1'b0, 1'b0);
        send_frame(5, 8'hAA, 1'b0, 1'b0);
        idle(5, 1'b0);
        check("hold_valid", m_if.tvalid, 1);
        check("hold_data0", m_if.tdata, 8'hA0);
        send_frame(4, 8'hC0, 1'b0, 1'b0);
        idle(1, 1'b0);
        check("ovf_count", n_ovf, 1);
        check("ovf_on_tlast", ovf_tick - last_tick, 1);
        check("ovf_good", n_good, 3);
        check("hold_data1", m_if.tdata, 8'hA0);
        check("no_out_stalled", got_d.size(), 0);
        idle(60, 1'b1);
        check("ovf_beats", got_d.size(), 15);
        check("ovf_seq", seq_errors(8'hA0, 5), 0);

        // Asynchronous reset mid-frame with a held output beat
        clear_obs();
        send_frame(4, 8'hD0, 1'b0, 1'b0);
        idle(6, 1'b0);
        check("pre_rst_valid", m_if.tvalid, 1);
        tick(1'b1, 8'hE0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'hE1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        s_if.tvalid = 1'b0;
        #1;
        check("async_rst_tvalid", m_if.tvalid, 0);
        check("async_rst_tready", s_if.tready, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("tready_after_rst2", s_if.tready, 1);
        clear_obs();
        idle(10, 1'b1);
        check("empty_after_rst", got_d.size(), 0);
        send_frame(3, 8'hF0, 1'b0, 1'b1);
        idle(20, 1'b1);
        check("post_rst_beats", got_d.size(), 3);
        check("post_rst_seq", seq_errors(8'hF0, 3), 0);
        check("post_rst_good", n_good, 1);
        check("post_rst_drops", n_bad + n_ovf, 0);

        // Random frames against a frame-level reference model; source is
        // throttled so occupancy never exceeds DEPTH (no overflow expected)
        clear_obs();
        exp_d.delete(); exp_l.delete(); exp_u.delete();
        timeouts = 0; exp_good_cnt = 0; exp_bad_cnt = 0;
        for (int f = 0; f < 200; f++) begin
            int   len;
            logic bad;
            logic [7:0] fd[$];
            logic       fu[$];
            len = $urandom_range(1, 12);
            bad = ($urandom_range(0, 9) == 0);
            waited = 0;
            while ((exp_d.size() - got_d.size()) + len > DEPTH && waited < 300) begin
                tick(1'b0, 8'h00, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
                waited++;
            end
            if (waited >= 300) timeouts++;
            fd.delete(); fu.delete();
            for (int i = 0; i < len; i++) begin
                logic [7:0] d;
                logic       u;
                if ($urandom_range(0, 3) == 0) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
                d = 8'($urandom);
                u = (i == len - 1) ? bad : 1'($urandom_range(0, 1));
                tick(1'b1, d, (i == len - 1), u, 1'($urandom_range(0, 1)));
                fd.push_back(d);
                fu.push_back(u);
            end
            if (bad) begin
                exp_bad_cnt++;
            end else begin
                exp_good_cnt++;
                for (int i = 0; i < len; i++) begin
                    exp_d.push_back(fd[i]);
                    exp_l.push_back(i == len - 1);
                    exp_u.push_back(fu[i]);
                end
            end
        end
        waited = 0;
        while (got_d.size() < exp_d.size() && waited < 1000) begin
            tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            waited++;
        end
        idle(5, 1'b1);
        mism = 0;
        for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
            if (got_d[i] != exp_d[i] || got_l[i] != exp_l[i] || got_u[i] != exp_u[i]) mism++;
        end
        check("rand_timeouts", timeouts + ((waited >= 1000) ? 1 : 0), 0);
        check("rand_beats", got_d.size(), exp_d.size());
        check("rand_stream", mism, 0);
        check("rand_keep", keep_bad, 0);
        check("rand_good", n_good, exp_good_cnt);
        check("rand_bad", n_bad, exp_bad_cnt);
        check("rand_ovf", n_ovf, 0);
        check("rand_s_tready", tready_low, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/axis_frame_fifo_sf.md
Name: axis_frame_fifo_sf

Overview:
- Store-and-forward frame FIFO placed on each input of the arbitrated stream mux.
- It presents only complete, committed frames downstream. The mux arbiter therefore never stalls mid-packet waiting on a slow or bursty source.
- Frames that overflow the buffer or end with a bad-frame flag are discarded in full.
- The write side never back-pressures, which makes the block suitable behind MAC receive paths.

Parameters:
- DEPTH, 1024: buffer capacity in words; power of two, at least 4.
- DATA_WIDTH, 8: tdata width in bits.
- KEEP_ENABLE, (DATA_WIDTH>8): store and propagate tkeep.
- KEEP_WIDTH, (DATA_WIDTH/8): tkeep width.
- USER_ENABLE, 1: store and propagate tuser.
- USER_WIDTH, 1: tuser width.
- DROP_BAD_FRAME, 1: discard a frame when tuser[0]=1 on its tlast beat.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- s_axis_tdata  in  DATA_WIDTH  input data.
- s_axis_tkeep  in  KEEP_WIDTH  input byte enables.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  input end of frame.
- s_axis_tuser  in  USER_WIDTH  input user; bit 0 is the bad-frame flag.
- m_axis_tdata  out  DATA_WIDTH  output data.
- m_axis_tkeep  out  KEEP_WIDTH  output byte enables; all ones when KEEP_ENABLE=0.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- m_axis_tlast  out  1  output end of frame.
- m_axis_tuser  out  USER_WIDTH  output user; zero when USER_ENABLE=0.
- status_overflow  out  1  one-cycle pulse when a frame is dropped for lack of space.
- status_bad_frame  out  1  one-cycle pulse when a frame is dropped for the bad-frame flag.
- status_good_frame  out  1  one-cycle pulse when a frame is committed.

Behaviour:
- Reset (asynchronous assert, release synchronous to clk):
  - all pointers = 0, drop_frame = 0;
  - m_axis_tvalid = 0, s_axis_tready = 0;
  - all status outputs = 0.
  - s_axis_tready goes to 1 on the first clk edge after rst deasserts.
- Pointers are ADDR_WIDTH+1 bits wide, with ADDR_WIDTH = $clog2(DEPTH):
  - wr_ptr_commit: end of the last committed frame.
  - wr_ptr_cur: speculative write position.
  - rd_ptr: read position.
- Full condition: wr_ptr_cur - rd_ptr == DEPTH (MSB differs, lower bits equal).
- Empty condition (no committed data): wr_ptr_commit == rd_ptr.
- s_axis_tready is held 1 outside reset. A beat is accepted when s_axis_tvalid=1.
- Accepted beat, not full, drop_frame=0:
  - write {tdata, tkeep, tlast, tuser} to the RAM at wr_ptr_cur;
  - wr_ptr_cur increments.
- Accepted beat while full, or while drop_frame=1:
  - the beat is discarded;
  - drop_frame is set and wr_ptr_cur is restored to wr_ptr_commit.
  - If this beat also carries tlast: drop_frame clears and status_overflow pulses on the next cycle. Otherwise status_overflow pulses on the tlast beat that ends the dropped frame.
- Accepted tlast beat, written normally:
  - DROP_BAD_FRAME=1 and tuser[0]=1: wr_ptr_cur is restored to wr_ptr_commit and status_bad_frame pulses.
  - Otherwise: wr_ptr_commit is set to wr_ptr_cur+1 and status_good_frame pulses.
- A frame longer than DEPTH words is always dropped as overflow. The FIFO never holds a partial frame visible to the read side.
- Read side:
  - RAM read is synchronous with 1-cycle latency, followed by an output register stage.
  - A read is issued when not empty and (output register empty or m_axis_tready=1); rd_ptr increments on issue.
  - m_axis_tvalid asserts the cycle after the read data returns.
  - With sustained m_axis_tready=1: one beat per cycle, no bubbles.
- Latency: tlast accepted at edge N -> wr_ptr_commit updated at N+1 -> m_axis_tvalid=1 at N+3 at the earliest, when the FIFO was empty.
- Output holds stable (data, tlast, tuser) while m_axis_tvalid=1 and m_axis_tready=0.
- Simultaneous write-commit and read in the same cycle are independent; the full check uses the registered rd_ptr.
- Pointer arithmetic wraps modulo 2*DEPTH. Wrap-around of the RAM address is seamless.
- rst asserted mid-frame on either side: all stored and partial frames are lost. No status pulse is generated for them.

Test Plan:
- DEPTH=16, DATA_WIDTH=8: send a 5-beat frame 0x01..0x05, tuser=0, m_axis_tready=1 -> 5 output beats in order, tlast only on 0x05; status_good_frame single pulse; first m_axis_tvalid 3 cycles after the input tlast edge.
- Same frame with tuser=1 on tlast, DROP_BAD_FRAME=1 -> no output beats; status_bad_frame single pulse. A following good 3-beat frame emerges intact.
- m_axis_tready=0: write 3 good frames of 5 beats each (15 words), then a 4-beat frame -> 4th frame dropped, status_overflow pulse on its tlast. After tready=1, exactly 15 beats are output.
- Send a 20-beat frame into an empty DEPTH=16 FIFO -> no output; one status_overflow pulse; s_axis_tready stays 1 throughout.
- Random m_axis_tready (50%) with 200 back-to-back frames of random length 1..12 -> output equals the input stream exactly, including across RAM pointer wrap.
- Assert rst for 1 cycle mid-frame, asynchronously between clk edges -> m_axis_tvalid drops immediately; the FIFO is empty afterwards; the next frame passes cleanly.
